// File: rtl/adam_aes_pkg.sv
// adam_aes_pkg: shared AES types, S-boxes and GF(2^8) helpers for the
// ADAM AES encipher/decipher pipelines. Byte 0 of a block is bits [127:120];
// the state is column-major, so byte index = 4*column + row.
package adam_aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] aes_block_t;
  // Forward key schedule, [0] = cipher key, [NUM_ROUNDS] = last round key.
  typedef logic [0:NUM_ROUNDS][127:0] aes_round_keys_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 sits in the top byte, so the bit offset of entry b is 8*(255-b) = {~b, 000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return INV_SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return gf_mul2(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return gf_mul2(gf_mul2(gf_mul2(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulB(input logic [7:0] b);
    return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulD(input logic [7:0] b);
    return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulE(input logic [7:0] b);
    return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ gf_mul2(b);
  endfunction

  // Row r rotates right by r columns.
  function automatic aes_block_t inv_shift_rows(input aes_block_t blk);
    logic [0:15][7:0] s;
    s = blk;
    return {s[0], s[13], s[10], s[7], s[4], s[1], s[14], s[11],
            s[8], s[5], s[2], s[15], s[12], s[9], s[6], s[3]};
  endfunction

  function automatic aes_block_t inv_sub_bytes(input aes_block_t blk);
    logic [0:15][7:0] s;
    s = blk;
    for (int i = 0; i < 16; i++) begin
      s[i[3:0]] = inv_sbox(s[i[3:0]]);
    end
    return s;
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t blk);
    logic [0:15][7:0] s;
    logic [0:15][7:0] o;
    logic [3:0]       b;
    s = blk;
    o = s;
    for (int c = 0; c < 4; c++) begin
      b = {c[1:0], 2'b00};
      o[b]         = gf_mulE(s[b]) ^ gf_mulB(s[b | 4'd1]) ^ gf_mulD(s[b | 4'd2]) ^ gf_mul9(s[b | 4'd3]);
      o[b | 4'd1]  = gf_mul9(s[b]) ^ gf_mulE(s[b | 4'd1]) ^ gf_mulB(s[b | 4'd2]) ^ gf_mulD(s[b | 4'd3]);
      o[b | 4'd2]  = gf_mulD(s[b]) ^ gf_mul9(s[b | 4'd1]) ^ gf_mulE(s[b | 4'd2]) ^ gf_mulB(s[b | 4'd3]);
      o[b | 4'd3]  = gf_mulB(s[b]) ^ gf_mulD(s[b | 4'd1]) ^ gf_mul9(s[b | 4'd2]) ^ gf_mulE(s[b | 4'd3]);
    end
    return o;
  endfunction

endpackage

// File: rtl/adam_aes_inv_round_module.sv
// adam_aes_inv_round_module: one combinational AES inverse round.
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when final).
module adam_aes_inv_round_module
  import adam_aes_pkg::*;
#(
  parameter bit IS_FINAL_ROUND = 1'b0
) (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);

  aes_block_t ark_s;

  // Apply one inverse round to the incoming state.
  always_comb begin
    ark_s = inv_sub_bytes(inv_shift_rows(state_in)) ^ round_key;
    if (IS_FINAL_ROUND) begin
      state_out = ark_s;
    end else begin
      state_out = inv_mix_columns(ark_s);
    end
  end

endmodule

// File: rtl/adam_aes_decipher_pipelined.sv
// adam_aes_decipher_pipelined: 11-stage AES-128 inverse cipher, one block per
// cycle, whole-pipeline stall when the output is held. Uses the forward key
// schedule in reverse. Optional macro ADAM_AES_DEC_STATS_EN adds block and
// stall counters.
module adam_aes_decipher_pipelined
  import adam_aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,     // AES-128 only
  parameter bit RESET_DATA = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            key_load,
  input  aes_round_keys_t round_keys,
  output logic            key_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_block,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_block,
  output logic            busy
`ifdef ADAM_AES_DEC_STATS_EN
  ,
  output logic [31:0]     blk_in_cnt,
  output logic [31:0]     blk_out_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  logic [0:NUM_ROUNDS] valid_d, valid_q;
  aes_block_t          data_d  [0:NUM_ROUNDS];
  aes_block_t          data_q  [0:NUM_ROUNDS];
  aes_block_t          stage_s [0:NUM_ROUNDS];
  aes_round_keys_t     kbank_d, kbank_q;
  logic                adv_s, accept_s, busy_s;

  // Stage 0 is a plain whitening with the last round key.
  assign stage_s[0] = in_block ^ kbank_q[NUM_ROUNDS];

  for (genvar r = 1; r <= NUM_ROUNDS; r++) begin : g_round
    adam_aes_inv_round_module #(
      .IS_FINAL_ROUND(r == NUM_ROUNDS)
    ) u_round (
      .state_in (data_q[r-1]),
      .round_key(kbank_q[NUM_ROUNDS-r]),
      .state_out(stage_s[r])
    );
  end

  // Advance decision, valid shift and guarded key-bank update.
  always_comb begin
    adv_s    = !(valid_q[NUM_ROUNDS] && !out_ready);
    accept_s = in_valid && adv_s;
    busy_s   = |valid_q;
    if (adv_s) begin
      valid_d = {accept_s, valid_q[0:NUM_ROUNDS-1]};
    end else begin
      valid_d = valid_q;
    end
    if (key_load && !busy_s) begin
      kbank_d = round_keys;
    end else begin
      kbank_d = kbank_q;
    end
  end

  // Stage data moves only when the whole pipeline advances.
  always_comb begin
    if (adv_s) begin
      data_d = stage_s;
    end else begin
      data_d = data_q;
    end
  end

  // Valid bits and key bank always reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      kbank_q <= '0;
    end else begin
      valid_q <= valid_d;
      kbank_q <= kbank_d;
    end
  end

  if (RESET_DATA) begin : g_data_rst
    // Stage data registers with reset to zero.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '{default: '0};
      end else begin
        data_q <= data_d;
      end
    end
  end else begin : g_data_norst
    // Stage data registers without reset; validity is tracked by valid_q.
    always_ff @(posedge clk) begin
      data_q <= data_d;
    end
  end

  // in_ready follows out_ready combinationally so a drained output frees the pipe.
  assign in_ready  = adv_s;
  assign out_valid = valid_q[NUM_ROUNDS];
  assign out_block = data_q[NUM_ROUNDS];
  assign busy      = busy_s;
  assign key_ready = !busy_s;

`ifdef ADAM_AES_DEC_STATS_EN
  logic [31:0] blk_in_cnt_d, blk_in_cnt_q;
  logic [31:0] blk_out_cnt_d, blk_out_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Free-running wrap-around statistics counters.
  always_comb begin
    blk_in_cnt_d  = blk_in_cnt_q  + (accept_s ? 32'd1 : 32'd0);
    blk_out_cnt_d = blk_out_cnt_q + ((valid_q[NUM_ROUNDS] && out_ready) ? 32'd1 : 32'd0);
    stall_cnt_d   = stall_cnt_q   + (adv_s ? 32'd0 : 32'd1);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_in_cnt_q  <= 32'd0;
      blk_out_cnt_q <= 32'd0;
      stall_cnt_q   <= 32'd0;
    end else begin
      blk_in_cnt_q  <= blk_in_cnt_d;
      blk_out_cnt_q <= blk_out_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign blk_in_cnt  = blk_in_cnt_q;
  assign blk_out_cnt = blk_out_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_adam_aes_decipher_pipelined.sv
// tb_adam_aes_decipher_pipelined: directed FIPS-197 vectors, a forward-cipher
// reference model for further vectors, streaming/backpressure, key-load guard,
// mid-flight reset and (with ADAM_AES_DEC_STATS_EN) counter checks.
module tb_adam_aes_decipher_pipelined;
  import adam_aes_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            key_load;
  aes_round_keys_t round_keys;
  logic            key_ready;
  logic            in_valid;
  logic            in_ready;
  aes_block_t      in_block;
  logic            out_valid;
  logic            out_ready;
  aes_block_t      out_block;
  logic            busy;
`ifdef ADAM_AES_DEC_STATS_EN
  logic [31:0]     blk_in_cnt, blk_out_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  adam_aes_decipher_pipelined dut (
    .clk(clk), .reset_n(reset_n), .key_load(key_load), .round_keys(round_keys),
    .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .busy(busy)
`ifdef ADAM_AES_DEC_STATS_EN
    , .blk_in_cnt(blk_in_cnt), .blk_out_cnt(blk_out_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    aes_block_t ct;
    aes_block_t pt;
    logic [1:0] key_sel;
    string      name;
  } vec_t;

  int              n_vec = 0;
  int              n_bad = 0;
  aes_block_t      exp_q [$];
  aes_round_keys_t rks [4];
  vec_t            vtab [8];

  // ---------------- reference model: forward AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_round_keys_t key_exp(input aes_block_t key);
    logic [0:43][31:0] w;
    logic [31:0]       tmp;
    logic [7:0]        rcon;
    int                p, q;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      p = i - 1; q = i - 4;
      tmp = w[p[5:0]];
      if (i[1:0] == 2'b00) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rcon, 24'h000000};
        rcon = xt(rcon);
      end
      w[i[5:0]] = w[q[5:0]] ^ tmp;
    end
    return w;
  endfunction

  function automatic aes_block_t aes_enc(input aes_block_t pt, input aes_round_keys_t rk);
    logic [0:15][7:0] s, t;
    logic [3:0]       b;
    logic [7:0]       a0, a1, a2, a3;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i[3:0]] = sbox(s[i[3:0]]);
      s = {t[0], t[5], t[10], t[15], t[4], t[9], t[14], t[3],
           t[8], t[13], t[2], t[7], t[12], t[1], t[6], t[11]};
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          b = {c[1:0], 2'b00};
          a0 = s[b]; a1 = s[b | 4'd1]; a2 = s[b | 4'd2]; a3 = s[b | 4'd3];
          s[b]        = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[b | 4'd1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[b | 4'd2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[b | 4'd3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ rk[r[3:0]];
    end
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic load_key(input aes_round_keys_t rk);
    round_keys = rk;
    key_load   = 1'b1;
    #1;
    check("key_ready_idle", {127'd0, key_ready}, 128'd1);
    @(posedge clk); @(negedge clk);
    key_load = 1'b0;
  endtask

  // Single block through an idle pipe with out_ready=1; checks exact latency.
  task automatic apply_one(input aes_block_t ct, input aes_block_t pt, input string tag);
    int cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_block  = ct;
    #1;
    check({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy"}, {127'd0, busy}, 128'd1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 128'(cnt), 128'd10);
    check({tag, "_data"}, out_block, pt);
    @(posedge clk); @(negedge clk);
    check({tag, "_drained"}, {126'd0, out_valid, busy}, 128'd0);
  endtask

  // Collect outstanding expected blocks with out_ready=1.
  task automatic drain(input string tag);
    int cyc;
    aes_block_t e;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        check({tag, "_data"}, out_block, e);
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 128'(exp_q.size()), 128'd0);
  endtask

  // mode 0: out_ready=1; mode 1: random 50%; mode 2: hold out_ready low for 4 output cycles.
  task automatic run_stream(input int n, input int mode, input aes_round_keys_t rk, input string tag);
    int         sent, got, cyc, first_out, last_out, stall_left;
    logic       held_v, need_new;
    aes_block_t held_b, pt, ct, e;
    sent = 0; got = 0; cyc = 0; first_out = -1; last_out = -1; stall_left = 4;
    held_v = 1'b0; held_b = '0; need_new = 1'b1; pt = '0; ct = '0;
    while ((sent < n || exp_q.size() != 0) && cyc < 2000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 1) == 1);
        2: begin
          out_ready = !(out_valid && stall_left > 0);
          if (out_valid && stall_left > 0) stall_left--;
        end
        default: out_ready = 1'b1;
      endcase
      if (sent < n) begin
        if (need_new) begin
          pt = {$urandom(), $urandom(), $urandom(), $urandom()};
          ct = aes_enc(pt, rk);
          need_new = 1'b0;
        end
        in_valid = 1'b1;
        in_block = ct;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check({tag, "_in_ready"}, {127'd0, in_ready}, {127'd0, !(out_valid && !out_ready)});
      if (held_v) check({tag, "_hold_stable"}, {126'd0, out_valid, 1'b0} ^ out_block, {126'd0, 1'b1, 1'b0} ^ held_b);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_output"}, 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_data"}, out_block, e);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      held_v = out_valid && !out_ready;
      held_b = out_block;
      if (in_valid && in_ready) begin
        exp_q.push_back(pt);
        sent++;
        need_new = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, 128'(got), 128'(n));
    if (mode == 0) check({tag, "_back_to_back"}, 128'(last_out - first_out), 128'(n - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    aes_block_t p;
    logic [2:0] cur_key;
    reset_n = 1'b0; key_load = 1'b0; round_keys = '0;
    in_valid = 1'b0; in_block = '0; out_ready = 1'b1;

    rks[0] = key_exp(128'h000102030405060708090a0b0c0d0e0f);
    rks[1] = key_exp(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rks[2] = key_exp(128'h0f1571c947d9e8590cb7add6af7f6798);
    rks[3] = '0;

    vtab[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 2'd0, "fips_c1"};
    vtab[1] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 2'd1, "fips_b"};
    vtab[2] = '{'0, 128'h0, 2'd0, "pt_zero"};
    vtab[3] = '{'0, {128{1'b1}}, 2'd2, "pt_ones"};
    vtab[4] = '{'0, 128'h0123456789abcdeffedcba9876543210, 2'd2, "pt_ramp"};
    vtab[5] = '{'0, 128'h80000000000000000000000000000000, 2'd1, "pt_msb"};
    vtab[6] = '{'0, 128'hdeadbeefcafef00d0badc0de12345678, 2'd1, "pt_mixed"};
    vtab[7] = '{'0, 128'h00000000000000000000000000000001, 2'd0, "pt_lsb"};
    for (int i = 2; i < 8; i++) vtab[i[2:0]].ct = aes_enc(vtab[i[2:0]].pt, rks[vtab[i[2:0]].key_sel]);

    // Reset state
    #12;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_key_ready", {127'd0, key_ready}, 128'd1);
    check("rst_out_block", out_block, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Key bank resets to zero: decrypt with an all-zero schedule
    p = 128'h55aa55aa00ff00ff1122334455667788;
    apply_one(aes_enc(p, rks[3]), p, "zero_kbank");

    // Table-driven single-block vectors
    cur_key = 3'd4;
    for (int i = 0; i < 8; i++) begin
      if ({1'b0, vtab[i[2:0]].key_sel} != cur_key) begin
        load_key(rks[vtab[i[2:0]].key_sel]);
        cur_key = {1'b0, vtab[i[2:0]].key_sel};
      end
      apply_one(vtab[i[2:0]].ct, vtab[i[2:0]].pt, vtab[i[2:0]].name);
    end

    // Streaming and backpressure
    load_key(rks[2]);
    run_stream(64, 0, rks[2], "stream");
    run_stream(20, 1, rks[2], "bp");

    // Key load while busy is ignored
    load_key(rks[0]);
    for (int i = 0; i < 3; i++) begin
      p = {4{$urandom()}};
      in_valid = 1'b1;
      in_block = aes_enc(p, rks[0]);
      exp_q.push_back(p);
      if (i == 2) begin
        round_keys = rks[1];
        key_load   = 1'b1;
        #1;
        check("key_ready_busy", {127'd0, key_ready}, 128'd0);
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; key_load = 1'b0;
    drain("key_busy");
    for (int i = 0; i < 5 && busy; i++) begin
      @(posedge clk); @(negedge clk);
    end
    check("key_busy_idle", {127'd0, busy}, 128'd0);
    load_key(rks[1]);
    p = 128'hfeedface0123456789abcdef00c0ffee;
    apply_one(aes_enc(p, rks[1]), p, "key_after");

    // Reset mid-flight
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_block = {4{$urandom()}};
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_reset_busy", {127'd0, busy}, 128'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("post_rst_quiet_%0d", i), {126'd0, out_valid, busy}, 128'd0);
    end

    // Fixed stall pattern (and counters when built with stats)
    load_key(rks[1]);
    run_stream(10, 2, rks[1], "stall4");
`ifdef ADAM_AES_DEC_STATS_EN
    check("blk_in_cnt", 128'(blk_in_cnt), 128'd10);
    check("blk_out_cnt", 128'(blk_out_cnt), 128'd10);
    check("stall_cnt", 128'(stall_cnt), 128'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/adam_aes_decipher_pipelined.md
Name: adam_aes_decipher_pipelined

Overview:
Fully pipelined AES-128 inverse cipher. It is the decrypt counterpart of the AES encipher pipeline in the ADAM AES peripheral core.
- Consumes the same forward key schedule (round_keys[0:10]) and applies it in reverse order.
- 11 registered stages; accepts one block per cycle.
- valid/ready handshake on both ends with whole-pipeline backpressure.
- Sits between the AES register front-end and the output FIFO.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; fixed at 10, AES-128 only.
RESET_DATA, 1, 1 = stage data registers reset to zero; 0 = data registers have no reset (valid bits always reset).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
key_load  in  1  latch round_keys into internal key bank; honoured only when busy=0
round_keys  in  128 x [0:10]  forward key schedule; [0] = cipher key, [10] = last round key
key_ready  out  1  high when key_load will be honoured (busy=0)
in_valid  in  1  in_block valid
in_ready  out  1  pipeline accepts in_block this cycle
in_block  in  128  ciphertext
out_valid  out  1  out_block valid
out_ready  in  1  downstream accepts out_block
out_block  out  128  plaintext
busy  out  1  any stage valid

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk.
  - All stage valid bits cleared; out_valid=0, busy=0, in_ready=1, key_ready=1.
  - Key bank = 0; out_block = 0 when RESET_DATA=1.
- Stage functions (SR = ShiftRows, SB = SubBytes, MC = MixColumns):
  - Stage 0: in_block ^ kbank[10].
  - Stages r=1..9: InvSR -> InvSB -> ^kbank[10-r] -> InvMC.
  - Stage 10: InvSR -> InvSB -> ^kbank[0].
  - Each stage output is registered together with a valid bit v[r].
- Advance enable: adv = !(v[10] && !out_ready).
  - adv=0: every stage register and valid bit holds (global stall, no bubble collapse).
  - adv=1: v[0] <= in_valid && in_ready, v[r] <= v[r-1].
- in_ready = adv. Combinational from out_ready; intentional.
- out_valid = v[10]; out_block = stage10 data register.
- Latency: block accepted at edge N appears with out_valid=1 after edge N+10, i.e. 11 cycles with no stall. Each stall cycle adds 1 cycle.
- Throughput: 1 block/cycle with out_ready held high.
- busy = |v.
- key_ready = !busy.
- key_load when busy=0: kbank <= round_keys at the edge.
- key_load when busy=1: ignored, kbank unchanged.
- key_load and an in_valid accept in the same cycle while busy=0:
  - key load takes effect at the edge.
  - The accepted block's stage 0 uses the OLD kbank[10]. Stages 1..10 see the new keys.
  - The bench must not do this; it is documented as undefined for data.
- Ordering: strict FIFO order, no reordering, no drop.
- out_valid stays asserted with stable out_block until out_ready (AXI-stream rule).
- reset_n asserted mid-stream: all in-flight blocks discarded immediately (async); no output after release until a new accept plus 11 cycles.
- No handshake on round_keys beyond key_load; it is don't-care otherwise.

Optional Feature:
ADAM_AES_DEC_STATS_EN
- Defined: adds outputs blk_in_cnt[31:0] and blk_out_cnt[31:0] plus stall_cnt[31:0].
  - blk_in_cnt increments on each input accept.
  - blk_out_cnt increments on each output accept.
  - stall_cnt increments on each cycle with adv=0.
  - All counters reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- adam_aes_pkg (shared with encipher):
  - aes_block_t (logic [127:0]), round-key array typedef, NUM_ROUNDS constant.
  - Forward and inverse S-box functions, gf_mul2/gf_mul3/gf_mul9/gf_mulB/gf_mulD/gf_mulE.
  - inv_shift_rows and inv_mix_columns functions.
- Sub-module: adam_aes_inv_round_module with parameter IS_FINAL_ROUND.
  - Purely combinational; instantiated 10 times.
  - Final round omits InvMixColumns.

Test Plan:
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f loaded, in_block 69c4e0d86a7b0430d8cdb78070b4c55a -> out_valid exactly 11 cycles after accept, out_block 00112233445566778899aabbccddeeff.
- Streaming: 64 random blocks back-to-back, out_ready=1 -> in_ready never drops, outputs on 64 consecutive cycles, each equal to the reference-model decrypt, in order.
- Backpressure: stream 20 blocks with out_ready random 50% -> no loss or duplication; out_block stable while out_valid && !out_ready; in_ready=0 exactly on those cycles.
- Key load while busy: load key A, send 3 blocks, pulse key_load with key B at cycle 2 -> key_ready=0, load ignored, all 3 decrypt with A. After busy=0, load B -> next block decrypts with B.
- Reset mid-flight: accept 5 blocks, assert reset_n low at cycle 4 -> out_valid=0, busy=0 immediately; no outputs for 15 cycles after release.
- ADAM_AES_DEC_STATS_EN build: 10 blocks accepted, 4 stall cycles -> blk_in_cnt=10, blk_out_cnt=10, stall_cnt=4.
